// File: rtl/store_write_buffer.sv
// Posted-write buffer between the D-cache store path and the system bus.
// CPU stores are accepted in one cycle into a small FIFO and drained in
// order through a bus-master FSM (IDLE -> REQ -> XFER -> REL). Loads are
// checked against every pending entry so the consumer can detect hazards.
// Optional feature macro: WB_FORWARD_EN (forward youngest matching store
// data on ld_data; when undefined ld_data is tied to zero).
module store_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   st_req,
    input  logic [ADDR_W-1:0]      st_addr,
    input  logic [DATA_W-1:0]      st_data,
    output logic                   st_ack,
    output logic                   full,
    output logic                   empty,
    input  logic [ADDR_W-1:0]      ld_addr,
    output logic                   ld_hit,
    output logic [DATA_W-1:0]      ld_data,
    input  logic                   flush,
    output logic                   flush_done,
    output logic                   bus_req,
    input  logic                   bus_grant,
    input  logic                   BUS_ready,
    output wire logic [ADDR_W-1:0] BUS_addr,
    output wire logic [DATA_W-1:0] BUS_data,
    output wire logic              BUS_RW
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] ONE     = (PW+1)'(1);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2,
        S_REL  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [PW:0]       wr_ptr_q, wr_ptr_d;
    logic [PW:0]       rd_ptr_q, rd_ptr_d;
    logic [PW:0]       count_q, count_d;
    logic              flush_q, flush_d;
    logic [ADDR_W-1:0] addr_mem_q [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];

    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic              drive_bus;
    logic [PW-1:0]     rd_idx;
    logic [DEPTH-1:0]  entry_match;

    assign rd_idx     = rd_ptr_q[PW-1:0];
    assign fifo_empty = (count_q == '0);
    assign full       = (count_q == DEPTH_C);
    // A completed bus write frees its slot in the same cycle, so a full
    // buffer can still take a store while the head is popping.
    assign pop        = (state_q == S_XFER) && bus_grant && BUS_ready;
    assign st_ack     = st_req && !clr && (!full || pop);
    assign push       = st_ack;
    assign empty      = fifo_empty && (state_q == S_IDLE);
    assign flush_done = flush_q && empty;
    assign drive_bus  = (state_q == S_XFER) && bus_grant;

    assign BUS_addr = drive_bus ? addr_mem_q[rd_idx] : {ADDR_W{1'bz}};
    assign BUS_data = drive_bus ? data_mem_q[rd_idx] : {DATA_W{1'bz}};
    assign BUS_RW   = drive_bus ? 1'b1 : 1'bz;

    // Per-slot hazard compare: a slot is live when its age behind the head
    // is below the occupancy count.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            logic [PW-1:0] age;
            assign age = PW'(gi) - rd_idx;
            assign entry_match[gi] = ({1'b0, age} < count_q) && (addr_mem_q[gi] == ld_addr);
        end
    endgenerate

    assign ld_hit = |entry_match;

`ifdef WB_FORWARD_EN
    // Walk from oldest to youngest so the youngest matching store wins.
    always_comb begin
        ld_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (entry_match[rd_idx + PW'(k)]) begin
                ld_data = data_mem_q[rd_idx + PW'(k)];
            end
        end
    end
`else
    assign ld_data = '0;
`endif

    // Pointer, occupancy and flush-latch next-state.
    always_comb begin
        wr_ptr_d = push ? (wr_ptr_q + ONE) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + ONE) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + ONE;
        end else if (!push && pop) begin
            count_d = count_q - ONE;
        end
        flush_d = flush || (flush_q && !flush_done);
    end

    // Bus-master FSM next state and request output.
    always_comb begin
        state_d = state_q;
        bus_req = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) state_d = S_REQ;
            end
            S_REQ: begin
                bus_req = 1'b1;
                if (bus_grant) state_d = S_XFER;
            end
            S_XFER: begin
                bus_req = 1'b1;
                if (bus_grant && BUS_ready) begin
                    state_d = S_REL;
                end else if (!bus_grant) begin
                    state_d = S_REQ;
                end
            end
            S_REL: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            flush_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            flush_q  <= flush_d;
        end
    end

    // Entry storage; contents need no reset since occupancy gates use.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem_q[wr_ptr_q[PW-1:0]] <= st_addr;
            data_mem_q[wr_ptr_q[PW-1:0]] <= st_data;
        end
    end

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer: single write latency, full/backpressure,
// load hazard (and forwarding when WB_FORWARD_EN is defined), lost grant,
// flush completion and reset in the middle of a transfer.
module tb_store_write_buffer;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

`ifdef WB_FORWARD_EN
    localparam logic [31:0] FWD_FIRST = 32'h0ab2112b;
    localparam logic [31:0] FWD_YOUNG = 32'h0ab2112c;
`else
    localparam logic [31:0] FWD_FIRST = 32'h0;
    localparam logic [31:0] FWD_YOUNG = 32'h0;
`endif

    logic              clk = 1'b0;
    logic              clr;
    logic              st_req;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              st_ack;
    logic              full;
    logic              empty;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_hit;
    logic [DATA_W-1:0] ld_data;
    logic              flush;
    logic              flush_done;
    logic              bus_req;
    logic              bus_grant;
    logic              bus_ready;
    wire  [ADDR_W-1:0] bus_addr;
    wire  [DATA_W-1:0] bus_data;
    wire               bus_rw;

    int tests_run    = 0;
    int tests_failed = 0;

    store_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .clr        (clr),
        .st_req     (st_req),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .st_ack     (st_ack),
        .full       (full),
        .empty      (empty),
        .ld_addr    (ld_addr),
        .ld_hit     (ld_hit),
        .ld_data    (ld_data),
        .flush      (flush),
        .flush_done (flush_done),
        .bus_req    (bus_req),
        .bus_grant  (bus_grant),
        .BUS_ready  (bus_ready),
        .BUS_addr   (bus_addr),
        .BUS_data   (bus_data),
        .BUS_RW     (bus_rw)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // With the grant held high, the second consecutive bus_req cycle is XFER.
    task automatic xfer_check(input string tag, input logic [31:0] a, input logic [31:0] d);
        logic prev;
        logic found;
        prev  = bus_req;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk); #1;
            if (bus_req && prev) begin
                found = 1'b1;
                $display("[TB] %s xfer addr=0x%08h data=0x%08h", tag, bus_addr, bus_data);
                check_eq({tag, "_addr"}, 64'(bus_addr), 64'(a));
                check_eq({tag, "_data"}, 64'(bus_data), 64'(d));
                check_eq({tag, "_rw"},   64'(bus_rw),   64'(1));
            end
            prev = bus_req;
        end
        check_eq({tag, "_seen"}, 64'(found), 64'(1));
    endtask

    task automatic push_store(input string tag, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        st_req  = 1'b1;
        st_addr = a;
        st_data = d;
        #1;
        $display("[TB] %s store addr=0x%08h data=0x%08h ack=%0b", tag, a, d, st_ack);
        check_eq({tag, "_ack"}, 64'(st_ack), 64'(1));
    endtask

    initial begin
        clr = 1'b1; st_req = 1'b1; st_addr = '0; st_data = '0;
        ld_addr = '0; flush = 1'b0; bus_grant = 1'b0; bus_ready = 1'b0;

        // Reset state, store request masked by clr.
        @(negedge clk); #1;
        check_eq("rst_st_ack",     64'(st_ack),     64'(0));
        check_eq("rst_empty",      64'(empty),      64'(1));
        check_eq("rst_full",       64'(full),       64'(0));
        check_eq("rst_bus_req",    64'(bus_req),    64'(0));
        check_eq("rst_ld_hit",     64'(ld_hit),     64'(0));
        check_eq("rst_ld_data",    64'(ld_data),    64'(0));
        check_eq("rst_flush_done", 64'(flush_done), 64'(0));
        clr = 1'b0; st_req = 1'b0;

        // Single store, immediate grant and ready.
        bus_grant = 1'b1; bus_ready = 1'b1;
        push_store("t1", 32'h14, 32'h0ab21123);
        @(negedge clk); st_req = 1'b0; #1;
        check_eq("t1_idle_empty", 64'(empty),   64'(0));
        check_eq("t1_idle_req",   64'(bus_req), 64'(0));
        @(negedge clk); #1;
        check_eq("t1_req",        64'(bus_req), 64'(1));
        @(negedge clk); #1;
        check_eq("t1_xfer_addr",  64'(bus_addr), 64'h14);
        check_eq("t1_xfer_data",  64'(bus_data), 64'h0ab21123);
        check_eq("t1_xfer_rw",    64'(bus_rw),   64'(1));
        @(negedge clk); #1;
        check_eq("t1_rel_req",    64'(bus_req), 64'(0));
        check_eq("t1_rel_empty",  64'(empty),   64'(0));
        @(negedge clk); #1;
        check_eq("t1_empty",      64'(empty),   64'(1));

        // Fill with grant withheld, then pop and push in the same cycle.
        bus_grant = 1'b0; bus_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_store("t2", 32'h100 + 32'(4 * i), 32'ha0000000 + 32'(i));
        end
        @(negedge clk);
        st_addr = 32'h110; st_data = 32'ha0000004; #1;
        check_eq("t2_full",      64'(full),   64'(1));
        check_eq("t2_5th_nack",  64'(st_ack), 64'(0));
        bus_grant = 1'b1; #1;
        check_eq("t2_req_nack",  64'(st_ack), 64'(0));
        @(negedge clk); bus_ready = 1'b1; #1;
        check_eq("t2_pop_ack",   64'(st_ack),   64'(1));
        check_eq("t2_head_addr", 64'(bus_addr), 64'h100);
        @(negedge clk); st_req = 1'b0; ld_addr = 32'h110; #1;
        check_eq("t2_still_full", 64'(full),   64'(1));
        check_eq("t2_hit_5th",    64'(ld_hit), 64'(1));
        for (int i = 1; i < 5; i++) begin
            xfer_check("t2", 32'h100 + 32'(4 * i), 32'ha0000000 + 32'(i));
        end
        @(negedge clk); @(negedge clk); #1;
        check_eq("t2_empty", 64'(empty), 64'(1));

        // Two stores to the same address: hazard and youngest forwarding.
        bus_grant = 1'b0; bus_ready = 1'b1; ld_addr = 32'h0;
        push_store("t3a", 32'h0, 32'h0ab2112b);
        check_eq("t3_hit_before_write", 64'(ld_hit), 64'(0));
        push_store("t3b", 32'h0, 32'h0ab2112c);
        check_eq("t3_hit_one",  64'(ld_hit),  64'(1));
        check_eq("t3_fwd_one",  64'(ld_data), 64'(FWD_FIRST));
        @(negedge clk); st_req = 1'b0; #1;
        check_eq("t3_hit_two",  64'(ld_hit),  64'(1));
        check_eq("t3_fwd_young", 64'(ld_data), 64'(FWD_YOUNG));
        ld_addr = 32'h4; #1;
        check_eq("t3_miss",     64'(ld_hit),  64'(0));
        ld_addr = 32'h0;
        bus_grant = 1'b1;
        xfer_check("t3_first", 32'h0, 32'h0ab2112b);
        xfer_check("t3_second", 32'h0, 32'h0ab2112c);
        @(negedge clk); #1;
        check_eq("t3_hit_drained", 64'(ld_hit), 64'(0));
        @(negedge clk); #1;
        check_eq("t3_empty", 64'(empty), 64'(1));

        // Grant lost during XFER before ready: no pop, entry re-driven.
        bus_grant = 1'b1; bus_ready = 1'b0; ld_addr = 32'h200;
        push_store("t4", 32'h200, 32'h5a5a0001);
        @(negedge clk); st_req = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        check_eq("t4_xfer_addr", 64'(bus_addr), 64'h200);
        check_eq("t4_xfer_req",  64'(bus_req),  64'(1));
        bus_grant = 1'b0;
        @(negedge clk); #1;
        check_eq("t4_back_req",  64'(bus_req), 64'(1));
        check_eq("t4_not_empty", 64'(empty),   64'(0));
        check_eq("t4_hit_kept",  64'(ld_hit),  64'(1));
        bus_grant = 1'b1;
        @(negedge clk); bus_ready = 1'b1; #1;
        check_eq("t4_redrive_addr", 64'(bus_addr), 64'h200);
        check_eq("t4_redrive_data", 64'(bus_data), 64'h5a5a0001);
        @(negedge clk); #1;
        check_eq("t4_rel_req",  64'(bus_req), 64'(0));
        check_eq("t4_hit_gone", 64'(ld_hit),  64'(0));
        @(negedge clk); #1;
        check_eq("t4_empty", 64'(empty), 64'(1));

        // Flush with three pending stores.
        bus_grant = 1'b0; bus_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_store("t5", 32'h400 + 32'(4 * i), 32'hf0000000 + 32'(i));
        end
        @(negedge clk); st_req = 1'b0; flush = 1'b1; #1;
        check_eq("t5_done_early", 64'(flush_done), 64'(0));
        @(negedge clk); flush = 1'b0; #1;
        check_eq("t5_done_pending", 64'(flush_done), 64'(0));
        bus_grant = 1'b1;
        for (int i = 0; i < 3; i++) begin
            xfer_check("t5", 32'h400 + 32'(4 * i), 32'hf0000000 + 32'(i));
        end
        @(negedge clk); #1;
        check_eq("t5_done_rel", 64'(flush_done), 64'(0));
        @(negedge clk); #1;
        check_eq("t5_done_idle", 64'(flush_done), 64'(1));
        check_eq("t5_empty",     64'(empty),      64'(1));
        @(negedge clk); #1;
        check_eq("t5_done_clear", 64'(flush_done), 64'(0));

        // Reset in the middle of a transfer.
        bus_grant = 1'b1; bus_ready = 1'b0; ld_addr = 32'h300;
        push_store("t6", 32'h300, 32'h33333333);
        @(negedge clk); st_req = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        check_eq("t6_xfer_req",  64'(bus_req),  64'(1));
        check_eq("t6_xfer_addr", 64'(bus_addr), 64'h300);
        check_eq("t6_hit",       64'(ld_hit),   64'(1));
        clr = 1'b1;
        @(negedge clk); clr = 1'b0; #1;
        check_eq("t6_req_dropped", 64'(bus_req), 64'(0));
        check_eq("t6_empty",       64'(empty),   64'(1));
        check_eq("t6_hit_cleared", 64'(ld_hit),  64'(0));
        check_eq("t6_full",        64'(full),    64'(0));
        bus_ready = 1'b1;
        @(negedge clk); @(negedge clk); #1;
        check_eq("t6_discarded", 64'(bus_req), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
